// File: rtl/spi_ram_pkg.sv
// Shared constants for the SPI RAM responder: opcodes, status value,
// field widths and the controller state encoding.
package spi_ram_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_RDSR   = 8'h05;
  localparam logic [7:0] STATUS_VAL = 8'h40;

  localparam int BYTE_BITS       = 8;
  localparam int ADDR_FIELD_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_READ   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_IGNORE = 3'd5
  } state_e;

  // MSB-first serial shift: the new bit enters at the LSB.
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
    return {cur[6:0], bit_in};
  endfunction

endpackage

// File: rtl/spi_ram_responder_if.sv
// Four-wire SPI bus between a controller (master) and the RAM responder (slave).
interface spi_ram_responder_if;

  logic spi_clk;
  logic spi_select;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_clk, output spi_select, output spi_mosi, input spi_miso);
  modport slave  (input spi_clk, input spi_select, input spi_mosi, output spi_miso);

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous input, plus a third flop used
// to detect rising and falling edges of the synchronised level.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the raw input through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  // Synchroniser register; cleared so that a select held low through reset
  // never produces a falling edge.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 RAM responder: READ (0x03) / WRITE (0x02) with 16-bit address,
// auto-incrementing wrapping address, host preload port when idle.
// Optional feature macro: SPI_RAM_RESP_STATUS_EN enables RDSR (0x05),
// which streams the constant status byte until deselect.
module spi_ram_responder
  import spi_ram_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  spi_ram_responder_if.slave       bus,
  input  logic                     load_en,
  input  logic [MEM_ADDR_BITS-1:0] load_addr,
  input  logic [7:0]               load_data,
  output logic                     busy,
  output logic                     cmd_err
);

  localparam logic [3:0] BIT_LAST  = 4'(BYTE_BITS - 1);
  localparam logic [3:0] ADDR_LAST = 4'(ADDR_FIELD_BITS - 1);

  logic sck_rise, sck_fall, sck_lvl_unused;
  logic sel_rise, sel_fall, sel_lvl_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge u_sync_sck (
    .clk(clk), .rst(rst), .din(bus.spi_clk),
    .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge u_sync_sel (
    .clk(clk), .rst(rst), .din(bus.spi_select),
    .level(sel_lvl_unused), .rise(sel_rise), .fall(sel_fall)
  );

  spi_sync_edge u_sync_mosi (
    .clk(clk), .rst(rst), .din(bus.spi_mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [7:0]               rx_q, rx_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]               tx_q, tx_d;
  logic                     miso_q, miso_d;
  logic                     rd_q, rd_d;
  logic                     stat_q, stat_d;
  logic                     err_q, err_d;
  logic                     wpend_q, wpend_d;
  logic [7:0]               wdata_q, wdata_d;

  logic [7:0]               mem_q [2**MEM_ADDR_BITS];
  logic                     mem_we;
  logic [MEM_ADDR_BITS-1:0] mem_wa;
  logic [7:0]               mem_wd;

  logic [7:0] rx_next;
  logic [7:0] rd_byte;
  logic       cmd_rdsr;
  logic       cmd_ok;

  assign rx_next = shift_in(rx_q, mosi_s);
  assign rd_byte = stat_q ? STATUS_VAL : mem_q[addr_q];

`ifdef SPI_RAM_RESP_STATUS_EN
  assign cmd_rdsr = (rx_next == CMD_RDSR);
`else
  assign cmd_rdsr = 1'b0;
`endif

  assign cmd_ok = (rx_next == CMD_READ) || (rx_next == CMD_WRITE) || cmd_rdsr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a deselect wins over everything else.
  always_comb begin
    state_d = state_q;
    if (sel_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (sel_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (sck_rise && cnt_q == BIT_LAST) begin
            if (!cmd_ok)      state_d = ST_IGNORE;
            else if (cmd_rdsr) state_d = ST_READ;
            else              state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (sck_rise && cnt_q == ADDR_LAST) state_d = rd_q ? ST_READ : ST_WRITE;
        end
        default: ;
      endcase
    end
  end

  // Datapath next values: bit counting, shifting, address and MISO.
  always_comb begin
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    addr_d  = addr_q;
    tx_d    = tx_q;
    miso_d  = 1'b0;
    rd_d    = rd_q;
    stat_d  = stat_q;
    err_d   = err_q;
    wpend_d = 1'b0;
    wdata_d = wdata_q;

    // A completed write byte lands in memory this cycle; step past it.
    if (wpend_q) addr_d = addr_q + MEM_ADDR_BITS'(1);

    if (sel_rise) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          rx_d   = '0;
          stat_d = 1'b0;
        end
        ST_CMD: begin
          if (sck_rise) begin
            rx_d  = rx_next;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == BIT_LAST) begin
              cnt_d  = '0;
              rd_d   = (rx_next == CMD_READ);
              stat_d = cmd_rdsr;
              err_d  = err_q | ~cmd_ok;
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            // Upper address bits fall off the top: addresses alias.
            addr_d = {addr_q[MEM_ADDR_BITS-2:0], mosi_s};
            cnt_d  = (cnt_q == ADDR_LAST) ? 4'd0 : cnt_q + 4'd1;
          end
        end
        ST_READ: begin
          miso_d = miso_q;
          if (sck_fall) begin
            if (cnt_q[2:0] == 3'd0) begin
              miso_d = rd_byte[7];
              tx_d   = {rd_byte[6:0], 1'b0};
            end else begin
              miso_d = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b0};
            end
            if (cnt_q == BIT_LAST) begin
              cnt_d = '0;
              if (!stat_q) addr_d = addr_q + MEM_ADDR_BITS'(1);
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ST_WRITE: begin
          if (sck_rise) begin
            rx_d = rx_next;
            if (cnt_q == BIT_LAST) begin
              cnt_d   = '0;
              wpend_d = 1'b1;
              wdata_d = rx_next;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      rx_q    <= '0;
      addr_q  <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      rd_q    <= 1'b0;
      stat_q  <= 1'b0;
      err_q   <= 1'b0;
      wpend_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      rd_q    <= rd_d;
      stat_q  <= stat_d;
      err_q   <= err_d;
      wpend_q <= wpend_d;
      wdata_q <= wdata_d;
    end
  end

  // Memory write port: SPI write has priority, host preload only while idle.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = load_addr;
    mem_wd = load_data;
    if (wpend_q) begin
      mem_we = 1'b1;
      mem_wa = addr_q;
      mem_wd = wdata_q;
    end else if (load_en && state_q == ST_IDLE) begin
      mem_we = 1'b1;
    end
  end

  // Storage array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // Outputs derived from state and registers.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    cmd_err      = err_q;
    bus.spi_miso = miso_q;
  end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Scoreboard bench for spi_ram_responder: a byte-array reference memory
// predicts every MISO byte; a monitor assembles MISO bytes on SCK rising
// edges and compares them against the expected queue.
module tb_spi_ram_responder;

  localparam int AW       = 6;
  localparam int MEM_SIZE = 64;

  typedef logic [7:0] bytes_t [$];

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          busy;
  logic          cmd_err;

  spi_ram_responder_if sif ();

  spi_ram_responder #(.MEM_ADDR_BITS(AW)) dut (
    .clk(clk), .rst(rst), .bus(sif),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] ref_mem [MEM_SIZE];
  logic [7:0] exp_q [$];
  bit         cap_en  = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: one MISO bit per SCK rising edge while capture is enabled.
  always @(posedge sif.spi_clk) begin
    if (cap_en) begin
      mon_byte = {mon_byte[6:0], sif.spi_miso};
      mon_cnt++;
      if (mon_cnt == 8) begin
        mon_cnt = 0;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL miso_byte: got %0h with no expected byte queued", mon_byte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (mon_byte !== e) begin
            miscompares++;
            $display("FAIL miso_byte: got %0h expected %0h at %0t", mon_byte, e, $time);
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_load(input logic [AW-1:0] a, input logic [7:0] d, input bit taken);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    if (taken) ref_mem[a] = d;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      sif.spi_mosi = tx[i];
      wait_clk(4);
      sif.spi_clk = 1'b1;
      wait_clk(4);
      sif.spi_clk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp);
    exp_q.push_back(exp);
    cap_en = 1'b1;
    spi_bits(tx, 8);
    cap_en = 1'b0;
  endtask

  task automatic select();
    sif.spi_select = 1'b0;
    wait_clk(4);
  endtask

  task automatic deselect();
    wait_clk(4);
    sif.spi_select = 1'b1;
    wait_clk(3);
    check("busy_after_deselect", busy, 1'b0);
    wait_clk(6);
  endtask

  task automatic spi_read(input logic [15:0] a, input int n);
    select();
    spi_byte(8'h03, 8'h00);
    spi_byte(a[15:8], 8'h00);
    spi_byte(a[7:0], 8'h00);
    for (int i = 0; i < n; i++)
      spi_byte(8'($urandom), ref_mem[(int'(a) + i) % MEM_SIZE]);
    deselect();
  endtask

  task automatic spi_write(input logic [15:0] a, input bytes_t data);
    select();
    spi_byte(8'h02, 8'h00);
    spi_byte(a[15:8], 8'h00);
    spi_byte(a[7:0], 8'h00);
    for (int i = 0; i < data.size(); i++) begin
      spi_byte(data[i], 8'h00);
      ref_mem[(int'(a) + i) % MEM_SIZE] = data[i];
    end
    deselect();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t     wq;
    logic [7:0] old;
    rst = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    sif.spi_clk = 1'b0; sif.spi_select = 1'b1; sif.spi_mosi = 1'b0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);
    check("reset_busy", busy, 1'b0);
    check("reset_miso", sif.spi_miso, 1'b0);
    check("reset_cmd_err", cmd_err, 1'b0);

    for (int i = 0; i < MEM_SIZE; i++) host_load(AW'(i), 8'($urandom), 1'b1);

    // Preload then a nominal 2-byte read.
    host_load(6'h10, 8'hAB, 1'b1);
    host_load(6'h11, 8'hCD, 1'b1);
    spi_read(16'h0010, 2);

    // Write across the top of memory, then read back across the wrap.
    wq.delete(); wq.push_back(8'h12); wq.push_back(8'h34);
    spi_write(16'h003F, wq);
    spi_read(16'h003F, 2);

    // Unsupported command: MISO stays low, sticky error.
    check("cmd_err_before_bad", cmd_err, 1'b0);
    select();
    spi_byte(8'h9F, 8'h00);
    spi_byte(8'($urandom), 8'h00);
    deselect();
    check("cmd_err_after_bad", cmd_err, 1'b1);
    spi_read(16'h0010, 2);

    // Partial write byte is discarded on deselect.
    select();
    spi_byte(8'h02, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h05, 8'h00);
    spi_bits(8'($urandom), 4);
    deselect();
    spi_read(16'h0005, 1);

    // Host load while busy is dropped; same load after deselect lands.
    select();
    spi_byte(8'h03, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h20, 8'h00);
    check("busy_during_read", busy, 1'b1);
    old = ref_mem[6'h20];
    host_load(6'h20, ~old, 1'b0);
    spi_byte(8'($urandom), old);
    deselect();
    spi_read(16'h0020, 1);
    host_load(6'h20, ~old, 1'b1);
    spi_read(16'h0020, 1);

    // Reset in the middle of a write: aborted, error cleared, the rest of
    // the still-selected transaction is ignored.
    select();
    spi_byte(8'h02, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h08, 8'h00);
    spi_bits(8'($urandom), 5);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    check("cmd_err_after_rst", cmd_err, 1'b0);
    check("busy_after_rst", busy, 1'b0);
    spi_bits(8'hFF, 8);
    spi_bits(8'h5A, 8);
    check("busy_ignoring_after_rst", busy, 1'b0);
    deselect();
    spi_read(16'h0008, 1);

    // Status command.
    select();
    spi_byte(8'h05, 8'h00);
`ifdef SPI_RAM_RESP_STATUS_EN
    spi_byte(8'($urandom), 8'h40);
    spi_byte(8'($urandom), 8'h40);
    deselect();
    check("cmd_err_rdsr", cmd_err, 1'b0);
`else
    spi_byte(8'($urandom), 8'h00);
    spi_byte(8'($urandom), 8'h00);
    deselect();
    check("cmd_err_rdsr", cmd_err, 1'b1);
`endif

    // Random mix of reads, writes and host loads with aliased addresses.
    for (int t = 0; t < 14; t++) begin
      int          op;
      int          n;
      logic [15:0] a;
      op = int'($urandom_range(0, 2));
      n  = int'($urandom_range(1, 4));
      a  = 16'($urandom);
      if (op == 0) begin
        spi_read(a, n);
      end else if (op == 1) begin
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
        spi_write(a, wq);
      end else begin
        host_load(AW'($urandom), 8'($urandom), 1'b1);
      end
    end

    // Whole-memory readback, wrapping once back to the start.
    spi_read(16'hC000, MEM_SIZE + 2);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_ram_responder.md
SPI_RAM_RESPONDER -- requirements
Module: spi_ram_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 6, log2 of storage size in bytes (64 bytes).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port spi_clk  input  1  SPI clock from the controller, mode 0, idle low.
REQ-005 SHALL have port spi_select  input  1  chip select, active-low.
REQ-006 SHALL have port spi_mosi  input  1  serial data from the controller, MSB first.
REQ-007 SHALL have port spi_miso  output  1  serial data to the controller, MSB first.
REQ-008 SHALL have port load_en  input  1  host preload write strobe.
REQ-009 SHALL have port load_addr  input  MEM_ADDR_BITS  host preload byte address.
REQ-010 SHALL have port load_data  input  8  host preload byte.
REQ-011 SHALL have port busy  output  1  high while a transaction is selected.
REQ-012 SHALL have port cmd_err  output  1  sticky flag: unsupported command received.

Function
REQ-013 SHALL pass spi_clk, spi_select and spi_mosi through 2-flop synchronisers and detect SCK rising and falling edges in the clk domain; clk SHALL be at least 4x the SCK frequency.
REQ-014 SHALL sample MOSI on each synchronised SCK rising edge and update MISO within 3 clk of each synchronised SCK falling edge.
REQ-015 SHALL use a state machine with states IDLE, CMD, ADDR, READ, WRITE, IGNORE.
REQ-016 SHALL move IDLE->CMD on the spi_select falling edge, with the bit counter cleared.
REQ-017 SHALL decode the command after 8 bits: 0x03 -> ADDR (read), 0x02 -> ADDR (write), any other value -> IGNORE, setting cmd_err.
REQ-018 SHALL shift 16 address bits in ADDR, use only the low MEM_ADDR_BITS, and silently ignore the upper bits (aliasing).
REQ-019 In READ, SHALL drive bit 7 of mem[addr] on the falling edge that follows the last address bit, then one bit per falling edge; after 8 bits SHALL increment addr and continue with the next byte.
REQ-020 In WRITE, SHALL write the byte to mem[addr] in the clk cycle after its 8th bit is sampled, then increment addr.
REQ-021 Address increment SHALL wrap from 2^MEM_ADDR_BITS-1 to 0.
REQ-022 A spi_select rising edge in any state SHALL return the FSM to IDLE within 3 clk; a partially received write byte SHALL be discarded.
REQ-023 SHALL hold spi_miso at 0 in IDLE, CMD, ADDR, WRITE and IGNORE.
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 A load_en write SHALL take effect the next clk when busy is low, and SHALL be ignored when busy is high (SPI has priority).
REQ-026 Sequential transfers of any length SHALL be supported; a 2-byte transfer is the nominal case.

Reset
REQ-027 On rst, SHALL set state IDLE, spi_miso 0, busy 0, cmd_err 0, and clear the bit counter, address and shift registers.
REQ-028 Memory contents SHALL be retained across rst; rst during a transaction SHALL abort it with no partial byte written.
REQ-029 After rst, the FSM SHALL ignore any transaction until spi_select is seen high and then falls again.

Configuration
REQ-030 With macro SPI_RAM_RESP_STATUS_EN defined, command 0x05 (RDSR) SHALL return status byte 0x40 on MISO, repeated until deselect, without setting cmd_err.
REQ-031 Without SPI_RAM_RESP_STATUS_EN, command 0x05 SHALL be treated as unsupported (IGNORE, cmd_err set).

Structure
REQ-032 Command opcodes (0x02, 0x03, 0x05), the status value 0x40 and the FSM state encoding SHALL live in the shared package spi_ram_pkg, alongside the controller's constants.
REQ-033 Synchroniser and edge detection SHALL be one sub-module, spi_sync_edge, instantiated once per input; the rest SHALL be flat.

Verification
REQ-034 Preload via load_en: mem[0x10]=0xAB and mem[0x11]=0xCD; SPI read 0x03,0x0010 for 2 bytes -> MISO returns 0xAB then 0xCD.
REQ-035 SPI write 0x02,0x003F with data 0x12,0x34 -> mem[0x3F]=0x12 and mem[0x00]=0x34 (wrap); a subsequent read confirms both.
REQ-036 Command 0x9F, then deselect -> cmd_err=1, MISO held 0, memory unchanged; the next 0x03 read works normally.
REQ-037 Write 0x02,0x0005, then deselect after 4 data bits -> mem[0x05] unchanged; busy=0 within 3 clk of deselect.
REQ-038 load_en to 0x20 while busy=1 -> mem[0x20] unchanged; after deselect, the same load succeeds.
REQ-039 With SPI_RAM_RESP_STATUS_EN, command 0x05 -> MISO returns 0x40; without it -> MISO 0 and cmd_err=1.
